// File: rtl/bit_scan_pkg.sv
// Shared types and defaults for the bit-scan sequencer and its index counter.
package bit_scan_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;
  localparam int SCAN_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/bit_scan_counter.sv
// Index counter driving the bit-select stage; flags the final index of a scan.
// Clear wins over increment; the count never wraps on its own because the FSM clears it at the last index.
module bit_scan_counter #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == LAST_IDX);
endmodule

// File: rtl/bit_scan_sequencer.sv
// Scans index 0..WIDTH-1 into a bit-select stage, rebuilds the word and offers it on valid/ready.
// Optional registered parity output when BIT_SCAN_PARITY_EN is defined.
module bit_scan_sequencer
  import bit_scan_pkg::*;
#(
  parameter int WIDTH = SCAN_WIDTH_DEFAULT,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             start,
  output logic             busy,
  output logic [IDX_W-1:0] index,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready
`ifdef BIT_SCAN_PARITY_EN
  ,
  output logic             parity
`endif
);
  scan_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             cnt_clr, cnt_inc, cnt_last;

  bit_scan_counter #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) u_counter (
    .clk_i (CLK),
    .rst_ni(ASYNCRESETN),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .idx_o (index),
    .last_o(cnt_last)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          data_d  = '0;
          cnt_clr = 1'b1;
        end
      end
      SCAN: begin
        data_d[index] = bit_in;
        if (cnt_last) begin
          state_d = DONE;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        // A start coinciding with the handshake chains straight into the next scan.
        if (ready) begin
          if (start) begin
            state_d = SCAN;
            data_d  = '0;
            cnt_clr = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign busy     = (state_q == SCAN);
  assign valid    = (state_q == DONE);
  assign data_out = data_q;

`ifdef BIT_SCAN_PARITY_EN
  logic parity_q;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^data_d;
    end
  end

  assign parity = parity_q;
`endif
endmodule

// File: tb/tb_bit_scan_sequencer.sv
// Bench for bit_scan_sequencer (WIDTH=8): the bit-select stage is modelled as bit_in = r_word[index];
// expected words are queued at start and popped by a monitor on every valid&ready handshake.
module tb_bit_scan_sequencer;
  logic       CLK = 1'b0;
  logic       ASYNCRESETN;
  logic       start;
  logic       busy;
  logic [2:0] index;
  logic       bit_in;
  logic [7:0] data_out;
  logic       valid;
  logic       ready;
  logic       parity;
  logic [7:0] r_word;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_hs = 0;

  always #5 CLK = ~CLK;

  assign bit_in = r_word[index];

`ifndef BIT_SCAN_PARITY_EN
  assign parity = 1'b0;
`endif

  bit_scan_sequencer #(.WIDTH(8), .IDX_W(3)) dut (
    .CLK        (CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .start      (start),
    .busy       (busy),
    .index      (index),
    .bit_in     (bit_in),
    .data_out   (data_out),
    .valid      (valid),
    .ready      (ready)
`ifdef BIT_SCAN_PARITY_EN
    ,
    .parity     (parity)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge CLK) begin
    if (ASYNCRESETN === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
      n_hs++;
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got word %0h expected none", data_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data", {24'd0, data_out}, {24'd0, e.d});
`ifdef BIT_SCAN_PARITY_EN
        check("sb_parity", {31'd0, parity}, {31'd0, e.p});
`endif
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  task automatic wait_valid(input string name, output time tv);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (valid === 1'b1) seen = 1'b1;
    end
    tv = $time;
    check(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_index(input string name, input logic [2:0] k);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (index === k && busy === 1'b1) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    time tv1, tv2, tdummy;
    bit  bad;

    ASYNCRESETN = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    r_word = 8'h00;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_index", {29'd0, index}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_parity", {31'd0, parity}, 32'd0);
    @(posedge CLK);
    #1 ASYNCRESETN = 1'b1;
    @(posedge CLK);
    #1;

    // 1: single scan, ready high
    r_word = 8'hFE;
    ready = 1'b1;
    sb.push_back('{d: 8'hFE, p: 1'b1});
    pulse_start();
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (index !== 3'(k) || busy !== 1'b1 || valid !== 1'b0) bad = 1'b1;
    end
    check("t1_index_seq", {31'd0, bad}, 32'd0);
    @(negedge CLK);
    check("t1_valid_up", {31'd0, valid}, 32'd1);
    check("t1_idx_done", {29'd0, index}, 32'd0);
    @(negedge CLK);
    check("t1_valid_one", {31'd0, valid}, 32'd0);
    check("t1_idle_busy", {31'd0, busy}, 32'd0);

    // 2: held output under backpressure, start ignored in DONE
    @(posedge CLK);
    #1 r_word = 8'hA5;
    ready = 1'b0;
    sb.push_back('{d: 8'hA5, p: 1'b0});
    pulse_start();
    wait_valid("t2_valid", tdummy);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1 start = (i % 2 == 0);
      @(negedge CLK);
      if (valid !== 1'b1 || data_out !== 8'hA5 || busy !== 1'b0) bad = 1'b1;
    end
    check("t2_hold", {31'd0, bad}, 32'd0);
    @(posedge CLK);
    #1 start = 1'b0;
    ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("t2_idle_valid", {31'd0, valid}, 32'd0);
    check("t2_idle_busy", {31'd0, busy}, 32'd0);

    // 3: start during SCAN is ignored
    r_word = 8'h6B;
    sb.push_back('{d: 8'h6B, p: 1'b1});
    @(posedge CLK);
    #1 pulse_start();
    wait_index("t3_idx3", 3'd3);
    pulse_start();
    wait_valid("t3_valid", tdummy);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    check("t3_no_restart", {31'd0, bad}, 32'd0);

    // 4: handshake and start in the same cycle
    @(posedge CLK);
    #1 r_word = 8'hC3;
    ready = 1'b0;
    sb.push_back('{d: 8'hC3, p: 1'b0});
    pulse_start();
    wait_valid("t4_valid", tdummy);
    @(posedge CLK);
    #1 ready = 1'b1;
    start = 1'b1;
    r_word = 8'h3C;
    sb.push_back('{d: 8'h3C, p: 1'b0});
    @(posedge CLK);
    #1 start = 1'b0;
    @(negedge CLK);
    check("t4_chain_busy", {31'd0, busy}, 32'd1);
    check("t4_chain_index", {29'd0, index}, 32'd0);
    check("t4_chain_clr", {24'd0, data_out}, 32'd0);
    wait_valid("t4_valid2", tdummy);
    @(negedge CLK);

    // 5: asynchronous reset mid-scan
    r_word = 8'h77;
    @(posedge CLK);
    #1 pulse_start();
    wait_index("t5_idx5", 3'd5);
    ASYNCRESETN = 1'b0;
    #1;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_index", {29'd0, index}, 32'd0);
    check("t5_data", {24'd0, data_out}, 32'd0);
    check("t5_valid", {31'd0, valid}, 32'd0);
    check("t5_parity", {31'd0, parity}, 32'd0);
    @(posedge CLK);
    #1 ASYNCRESETN = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (valid !== 1'b0) bad = 1'b1;
    end
    check("t5_no_valid", {31'd0, bad}, 32'd0);
    r_word = 8'h97;
    sb.push_back('{d: 8'h97, p: 1'b1});
    @(posedge CLK);
    #1 pulse_start();
    wait_valid("t5_valid_new", tdummy);

    // 6: back-to-back 00 then FF, throughput
    @(posedge CLK);
    #1 r_word = 8'h00;
    sb.push_back('{d: 8'h00, p: 1'b0});
    pulse_start();
    wait_valid("t6_valid1", tv1);
    r_word = 8'hFF;
    start = 1'b1;
    sb.push_back('{d: 8'hFF, p: 1'b0});
    @(posedge CLK);
    #1 start = 1'b0;
    wait_valid("t6_valid2", tv2);
    check("t6_period", 32'(tv2 - tv1), 32'd90);

    repeat (3) @(negedge CLK);
    check("sb_drain", 32'(sb.size()), 32'd0);
    check("hs_count", 32'(n_hs), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
